// File: rtl/udp_tx_sched_if.sv
// Bundle of requester-side and UDP-stack-side signals of the transmit scheduler.
// master is the scheduler's view; slave is the requesters plus stack.
interface udp_tx_sched_if;
  logic        req0;
  logic        req1;
  logic [15:0] len0;
  logic [15:0] len1;
  logic        src_valid0;
  logic        src_valid1;
  logic [7:0]  src_data0;
  logic [7:0]  src_data1;
  logic        src_ready0;
  logic        src_ready1;
  logic        done0;
  logic        done1;
  logic        err0;
  logic        err1;
  logic        arp_busy;
  logic        app_data_request;
  logic [15:0] app_data_length;
  logic        udp_send_ack;
  logic        app_data_in_valid;
  logic [7:0]  app_data_in;
  logic        mac_send_end;
  logic        grant;

  modport master (
    input  req0, req1, len0, len1,
    input  src_valid0, src_valid1, src_data0, src_data1,
    output src_ready0, src_ready1,
    output done0, done1, err0, err1,
    input  arp_busy,
    output app_data_request, app_data_length,
    input  udp_send_ack,
    output app_data_in_valid, app_data_in,
    input  mac_send_end,
    output grant
  );

  modport slave (
    output req0, req1, len0, len1,
    output src_valid0, src_valid1, src_data0, src_data1,
    input  src_ready0, src_ready1,
    input  done0, done1, err0, err1,
    output arp_busy,
    input  app_data_request, app_data_length,
    output udp_send_ack,
    input  app_data_in_valid, app_data_in,
    output mac_send_end,
    input  grant
  );
endinterface

// File: rtl/udp_tx_sched.sv
// Two-requester round-robin scheduler feeding single UDP datagrams into a UDP/IP/MAC stack.
// All outputs are registered; payload bytes appear one cycle after source acceptance.
//
// state    | meaning
// IDLE     | waiting for a request with ARP quiet; illegal lengths rejected here
// REQ      | app_data_request high, waiting for udp_send_ack or timeout
// XFER     | streaming payload bytes from the granted requester
// WAIT_END | payload done, waiting for mac_send_end or timeout
module udp_tx_sched #(
  parameter int MAX_LEN     = 1472,
  parameter int TIMEOUT_CYC = 125_000_000
) (
  input  logic           rgmii_clk,
  input  logic           rst,
  udp_tx_sched_if.master bus
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_XFER,
    S_WAIT_END
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   byte_cnt_q, byte_cnt_d;
  logic [CW-1:0] cyc_cnt_q, cyc_cnt_d;
  logic          grant_q, grant_d;
  logic          req_out_q, req_out_d;
  logic [1:0]    ready_q, ready_d;
  logic [1:0]    done_q, done_d;
  logic [1:0]    err_q, err_d;
  logic          dvalid_q, dvalid_d;
  logic [7:0]    dout_q, dout_d;

  logic          any_req;
  logic          pick;
  logic [15:0]   pick_len;
  logic          pick_bad;
  logic          sel_valid;
  logic [7:0]    sel_data;
  logic          fire;
  logic          cyc_expired;
  logic          pulse_busy;

  always_comb begin
    any_req     = bus.req0 | bus.req1;
    // With both requesting, the one not served last wins; otherwise whoever asks.
    pick        = (bus.req0 && bus.req1) ? ~grant_q : bus.req1;
    pick_len    = pick ? bus.len1 : bus.len0;
    pick_bad    = (pick_len == 16'd0) || (pick_len > 16'(MAX_LEN));
    sel_valid   = grant_q ? bus.src_valid1 : bus.src_valid0;
    sel_data    = grant_q ? bus.src_data1 : bus.src_data0;
    fire        = sel_valid && ready_q[grant_q];
    cyc_expired = (cyc_cnt_q == CW'(TIMEOUT_CYC - 1));
    // Holding off while a done/err pulse is out lets the requester drop req first.
    pulse_busy  = (done_q != 2'b00) || (err_q != 2'b00);

    state_d    = state_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    cyc_cnt_d  = cyc_cnt_q + CW'(1);
    grant_d    = grant_q;
    req_out_d  = req_out_q;
    ready_d    = ready_q;
    done_d     = 2'b00;
    err_d      = 2'b00;
    dvalid_d   = 1'b0;
    dout_d     = dout_q;

    case (state_q)
      S_IDLE: begin
        if (!bus.arp_busy && any_req && !pulse_busy) begin
          grant_d = pick;
          if (pick_bad) begin
            err_d = pick ? 2'b10 : 2'b01;
          end else begin
            len_d     = pick_len;
            req_out_d = 1'b1;
            cyc_cnt_d = '0;
            state_d   = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (bus.udp_send_ack) begin
          req_out_d  = 1'b0;
          byte_cnt_d = 16'd0;
          ready_d    = grant_q ? 2'b10 : 2'b01;
          state_d    = S_XFER;
        end else if (cyc_expired) begin
          req_out_d = 1'b0;
          err_d     = grant_q ? 2'b10 : 2'b01;
          state_d   = S_IDLE;
        end
      end
      S_XFER: begin
        if (fire) begin
          dvalid_d   = 1'b1;
          dout_d     = sel_data;
          byte_cnt_d = byte_cnt_q + 16'd1;
          if (byte_cnt_q == len_q - 16'd1) begin
            ready_d   = 2'b00;
            cyc_cnt_d = '0;
            state_d   = S_WAIT_END;
          end
        end
      end
      S_WAIT_END: begin
        if (bus.mac_send_end) begin
          done_d  = grant_q ? 2'b10 : 2'b01;
          state_d = S_IDLE;
        end else if (cyc_expired) begin
          err_d   = grant_q ? 2'b10 : 2'b01;
          state_d = S_IDLE;
        end
      end
      default: begin
        req_out_d = 1'b0;
        ready_d   = 2'b00;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge rgmii_clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= 16'd0;
      byte_cnt_q <= 16'd0;
      cyc_cnt_q  <= '0;
      grant_q    <= 1'b1;
      req_out_q  <= 1'b0;
      ready_q    <= 2'b00;
      done_q     <= 2'b00;
      err_q      <= 2'b00;
      dvalid_q   <= 1'b0;
      dout_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      cyc_cnt_q  <= cyc_cnt_d;
      grant_q    <= grant_d;
      req_out_q  <= req_out_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
      dvalid_q   <= dvalid_d;
      dout_q     <= dout_d;
    end
  end

  assign bus.src_ready0        = ready_q[0];
  assign bus.src_ready1        = ready_q[1];
  assign bus.done0             = done_q[0];
  assign bus.done1             = done_q[1];
  assign bus.err0              = err_q[0];
  assign bus.err1              = err_q[1];
  assign bus.app_data_request  = req_out_q;
  assign bus.app_data_length   = len_q;
  assign bus.app_data_in_valid = dvalid_q;
  assign bus.app_data_in       = dout_q;
  assign bus.grant             = grant_q;

endmodule

// File: tb/tb_udp_tx_sched.sv
// Directed bench for udp_tx_sched: arbitration, payload streaming, length rejects,
// timeouts, ARP hold-off and mid-transfer reset.
module tb_udp_tx_sched;
  logic rgmii_clk = 1'b0;
  logic rst;
  always #5 rgmii_clk = ~rgmii_clk;

  udp_tx_sched_if ifc ();

  udp_tx_sched #(.MAX_LEN(1472), .TIMEOUT_CYC(16)) dut (
    .rgmii_clk (rgmii_clk),
    .rst       (rst),
    .bus       (ifc.master)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] rx_q[$];
  int   lat_err    = 0;
  int   ready_err  = 0;
  int   req_hi_cnt = 0;
  int   done_cnt0  = 0;
  int   done_cnt1  = 0;
  int   err_cnt0   = 0;
  int   err_cnt1   = 0;
  logic       fire_prev = 1'b0;
  logic [7:0] data_prev = 8'd0;

  // Output stream must be exactly the accepted stream delayed by one cycle.
  always @(negedge rgmii_clk) begin
    lat_err <= lat_err + int'(ifc.app_data_in_valid !== fire_prev)
                       + int'(fire_prev && (ifc.app_data_in !== data_prev));
    fire_prev <= !rst && ((ifc.src_valid0 && ifc.src_ready0) ||
                          (ifc.src_valid1 && ifc.src_ready1));
    data_prev <= ifc.src_ready1 ? ifc.src_data1 : ifc.src_data0;
    ready_err <= ready_err + int'(ifc.src_ready0 && ifc.src_ready1)
                           + int'(ifc.src_ready0 && ifc.grant)
                           + int'(ifc.src_ready1 && !ifc.grant);
    req_hi_cnt <= req_hi_cnt + int'(ifc.app_data_request);
    done_cnt0  <= done_cnt0 + int'(ifc.done0);
    done_cnt1  <= done_cnt1 + int'(ifc.done1);
    err_cnt0   <= err_cnt0 + int'(ifc.err0);
    err_cnt1   <= err_cnt1 + int'(ifc.err1);
    if (ifc.app_data_in_valid) rx_q.push_back(ifc.app_data_in);
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge rgmii_clk);
    #1;
  endtask

  task automatic drive_src(input bit idx, input logic v, input logic [7:0] d);
    if (idx) begin
      ifc.src_valid1 = v;
      ifc.src_data1  = d;
    end else begin
      ifc.src_valid0 = v;
      ifc.src_data0  = d;
    end
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!ifc.app_data_request && n < 50) begin
      tick();
      n++;
    end
    check_eq({tag, "_req_seen"}, ifc.app_data_request, 1);
  endtask

  task automatic send_bytes(input bit idx, input int n, input logic [7:0] base,
                            input logic [7:0] step, input bit gap);
    int   i = 0;
    int   k = 0;
    logic v;
    logic r;
    while (i < n && k < 200) begin
      v = gap ? (k % 2 == 0) : 1'b1;
      drive_src(idx, v, 8'(base + step * i));
      r = idx ? ifc.src_ready1 : ifc.src_ready0;
      tick();
      if (v && r) i++;
      k++;
    end
    drive_src(idx, 1'b0, 8'd0);
    check_eq("bytes_sent", i, n);
  endtask

  // end_dly < 0 means the stack never reports mac_send_end.
  task automatic run_txn(input bit idx, input int n, input logic [7:0] base,
                         input logic [7:0] step, input bit gap, input int ack_dly,
                         input int end_dly, input bit drop, input bit arp_mid);
    int rx_base;
    rx_base = rx_q.size();
    wait_req("txn");
    check_eq("grant", ifc.grant, idx);
    check_eq("app_len", ifc.app_data_length, n);
    if (arp_mid) ifc.arp_busy = 1'b1;
    repeat (ack_dly) tick();
    check_eq("req_held", ifc.app_data_request, 1);
    ifc.udp_send_ack = 1'b1;
    tick();
    ifc.udp_send_ack = 1'b0;
    check_eq("req_low_xfer", ifc.app_data_request, 0);
    send_bytes(idx, n, base, step, gap);
    check_eq("ready_drop", idx ? ifc.src_ready1 : ifc.src_ready0, 0);
    if (end_dly >= 0) begin
      repeat (end_dly) tick();
      ifc.mac_send_end = 1'b1;
      tick();
      ifc.mac_send_end = 1'b0;
      check_eq("done_pulse", {ifc.done1, ifc.done0}, idx ? 2'b10 : 2'b01);
      check_eq("no_err", {ifc.err1, ifc.err0}, 0);
    end else begin
      repeat (15) tick();
      check_eq("wend_early", idx ? ifc.err1 : ifc.err0, 0);
      tick();
      check_eq("wend_timeout", {ifc.err1, ifc.err0}, idx ? 2'b10 : 2'b01);
      check_eq("wend_no_done", {ifc.done1, ifc.done0}, 0);
    end
    if (drop) begin
      if (idx) ifc.req1 = 1'b0;
      else     ifc.req0 = 1'b0;
    end
    tick();
    check_eq("pulse_1cyc", {ifc.done1, ifc.done0, ifc.err1, ifc.err0}, 0);
    check_eq("rx_count", rx_q.size() - rx_base, n);
    for (int i = 0; i < n; i++) begin
      if (rx_base + i < rx_q.size())
        check_eq("rx_byte", rx_q[rx_base + i], 8'(base + step * i));
    end
    if (arp_mid) ifc.arp_busy = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"},   ifc.app_data_request, 0);
    check_eq({tag, "_dval"},  ifc.app_data_in_valid, 0);
    check_eq({tag, "_rdy"},   {ifc.src_ready1, ifc.src_ready0}, 0);
    check_eq({tag, "_done"},  {ifc.done1, ifc.done0}, 0);
    check_eq({tag, "_err"},   {ifc.err1, ifc.err0}, 0);
    check_eq({tag, "_data"},  ifc.app_data_in, 0);
    check_eq({tag, "_len"},   ifc.app_data_length, 0);
    check_eq({tag, "_grant"}, ifc.grant, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    int e0;
    int d0;
    int d1;
    int e1;
    int n;

    rst = 1'b1;
    ifc.req0 = 1'b1;  ifc.req1 = 1'b1;
    ifc.len0 = 16'd2; ifc.len1 = 16'd2;
    ifc.src_valid0 = 1'b0; ifc.src_valid1 = 1'b0;
    ifc.src_data0 = 8'd0;  ifc.src_data1 = 8'd0;
    ifc.arp_busy = 1'b0;
    ifc.udp_send_ack = 1'b0;
    ifc.mac_send_end = 1'b0;
    repeat (3) tick();
    check_reset_outputs("rst");
    rst = 1'b0;

    // Both requesting from reset: 0, 1, 0.
    run_txn(1'b0, 2, 8'h01, 8'h01, 1'b0, 1, 2, 1'b0, 1'b0);
    run_txn(1'b1, 2, 8'h81, 8'h01, 1'b0, 1, 2, 1'b0, 1'b0);
    run_txn(1'b0, 2, 8'h05, 8'h01, 1'b0, 1, 2, 1'b0, 1'b0);
    ifc.req0 = 1'b0;
    ifc.req1 = 1'b0;
    tick();

    // Single datagram 11 22 33 44.
    ifc.len0 = 16'd4;
    ifc.req0 = 1'b1;
    run_txn(1'b0, 4, 8'h11, 8'h11, 1'b0, 3, 10, 1'b1, 1'b0);

    // Illegal lengths on requester 1.
    hi = req_hi_cnt;
    foreach (ifc.len1[i]) ;
    ifc.len1 = 16'd0;
    ifc.req1 = 1'b1;
    n = 0;
    while (!ifc.err1 && n < 20) begin tick(); n++; end
    check_eq("err1_len0", ifc.err1, 1);
    check_eq("err1_len0_grant", ifc.grant, 1);
    ifc.req1 = 1'b0;
    tick();
    check_eq("err1_len0_1cyc", ifc.err1, 0);
    ifc.len1 = 16'd1473;
    ifc.req1 = 1'b1;
    n = 0;
    while (!ifc.err1 && n < 20) begin tick(); n++; end
    check_eq("err1_len1473", ifc.err1, 1);
    ifc.req1 = 1'b0;
    repeat (2) tick();
    check_eq("err1_no_request", req_hi_cnt - hi, 0);

    // Request timeout with no ack.
    hi = req_hi_cnt;
    e0 = err_cnt0;
    ifc.len0 = 16'd8;
    ifc.req0 = 1'b1;
    n = 0;
    while (!ifc.err0 && n < 40) begin tick(); n++; end
    check_eq("req_to_err0", ifc.err0, 1);
    check_eq("req_to_req_low", ifc.app_data_request, 0);
    ifc.req0 = 1'b0;
    tick();
    check_eq("req_to_cycles", req_hi_cnt - hi, 16);
    check_eq("req_to_err_cnt", err_cnt0 - e0, 1);

    // ARP hold-off, then a gapped source; ARP rises again mid-transaction.
    hi = req_hi_cnt;
    ifc.arp_busy = 1'b1;
    ifc.req0 = 1'b1;
    repeat (6) tick();
    check_eq("arp_no_grant", req_hi_cnt - hi, 0);
    ifc.arp_busy = 1'b0;
    run_txn(1'b0, 8, 8'hA0, 8'h03, 1'b1, 2, 4, 1'b1, 1'b1);

    // Stack never signals end of frame.
    ifc.len0 = 16'd3;
    ifc.req0 = 1'b1;
    run_txn(1'b0, 3, 8'h50, 8'h01, 1'b0, 1, -1, 1'b1, 1'b0);

    check_eq("lat_mirror", lat_err, 0);
    check_eq("ready_excl", ready_err, 0);

    // Reset after 2 of 8 bytes.
    ifc.len0 = 16'd8;
    ifc.req0 = 1'b1;
    wait_req("abort");
    check_eq("abort_grant", ifc.grant, 0);
    ifc.udp_send_ack = 1'b1;
    tick();
    ifc.udp_send_ack = 1'b0;
    send_bytes(1'b0, 2, 8'h60, 8'h01, 1'b0);
    d0 = done_cnt0; e0 = err_cnt0; d1 = done_cnt1; e1 = err_cnt1;
    rst = 1'b1;
    ifc.len1 = 16'd3;
    ifc.req1 = 1'b1;
    tick();
    check_reset_outputs("abort_rst");
    rst = 1'b0;
    wait_req("post_rst");
    check_eq("post_rst_grant", ifc.grant, 0);
    check_eq("abort_no_pulse", (done_cnt0 - d0) + (err_cnt0 - e0) + (done_cnt1 - d1) + (err_cnt1 - e1), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/udp_tx_sched.md
UDP_TX_SCHED -- requirements
Module: udp_tx_sched

Interface
REQ-001 SHALL have parameter MAX_LEN, default 1472, largest legal UDP payload in bytes.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 125_000_000, cycles allowed in REQ and in WAIT_END states.
REQ-003 SHALL have port rgmii_clk  in  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports req0/req1  in  1  requester wants to send one datagram; level, held until done or err.
REQ-006 SHALL have ports len0/len1  in  16  payload byte count, stable while req high.
REQ-007 SHALL have ports src_valid0/src_valid1  in  1  requester byte valid.
REQ-008 SHALL have ports src_data0/src_data1  in  8  requester payload byte.
REQ-009 SHALL have ports src_ready0/src_ready1  out  1  scheduler accepts byte this cycle.
REQ-010 SHALL have ports done0/done1 and err0/err1  out  1  one-cycle completion and failure pulses.
REQ-011 SHALL have port arp_busy  in  1  ARP exchange in progress; no new grant while high.
REQ-012 SHALL have port app_data_request  out  1  send request to UDP/IP/MAC stack.
REQ-013 SHALL have port app_data_length  out  16  granted payload length.
REQ-014 SHALL have port udp_send_ack  in  1  stack ready to accept payload bytes.
REQ-015 SHALL have ports app_data_in_valid  out  1  and app_data_in  out  8  payload byte stream to stack.
REQ-016 SHALL have port mac_send_end  in  1  stack finished transmitting frame.
REQ-017 SHALL have port grant  out  1  index of current/last granted requester.

Function
REQ-018 SHALL implement states IDLE, REQ, XFER, WAIT_END.
REQ-019 IDLE: when arp_busy low and any req high, SHALL grant round-robin; requester not granted last wins ties; first grant after reset goes to 0.
REQ-020 On grant, if len is 0 or greater than MAX_LEN, SHALL pulse err of that requester next cycle and stay IDLE, pointer advanced.
REQ-021 Legal grant: SHALL latch len into app_data_length, set grant, enter REQ.
REQ-022 REQ: app_data_request SHALL be high exactly while in REQ; on udp_send_ack go to XFER.
REQ-023 XFER: src_ready of granted requester SHALL be high until byte count reaches length; other src_ready low at all times.
REQ-024 A byte SHALL transfer when src_valid and src_ready of the granted requester are both high; it appears on app_data_in with app_data_in_valid high exactly one cycle later.
REQ-025 Source stalls (src_valid low) SHALL produce gaps with app_data_in_valid low; no byte duplicated or dropped.
REQ-026 16-bit byte counter SHALL clear on entering XFER; on count reaching length, src_ready drops the same cycle the last byte is accepted and state goes to WAIT_END.
REQ-027 WAIT_END: on mac_send_end SHALL pulse done of granted requester one cycle and return to IDLE; new grant no earlier than the cycle after done.
REQ-028 A cycle counter SHALL clear on entry to REQ and WAIT_END; reaching TIMEOUT_CYC in either state SHALL pulse err of granted requester and return to IDLE.
REQ-029 udp_send_ack outside REQ and mac_send_end outside WAIT_END SHALL be ignored.
REQ-030 Requester dropping req mid-transaction SHALL NOT abort the transaction.
REQ-031 arp_busy rising after a grant SHALL NOT affect the transaction in progress.

Reset
REQ-032 With rst high at a clock edge, state SHALL be IDLE and app_data_request, app_data_in_valid, src_ready0/1, done0/1, err0/1 SHALL be 0; app_data_in, app_data_length SHALL be 0; grant SHALL be 1 so next grant goes to 0.
REQ-033 rst asserted mid-XFER SHALL abort without done or err pulse; the stack is not notified.

Verification
REQ-034 req0, len0=4, bytes 11 22 33 44 back-to-back, ack 3 cycles after request, mac_send_end 10 cycles later -> app_data_length=4, four valid bytes 11 22 33 44 each one cycle after acceptance, one done0 pulse.
REQ-035 req0 and req1 both high from reset, len=2 each -> grant 0 first, then 1, then 0; never both src_ready high.
REQ-036 req1 with len1=0, then len1=1473 -> err1 pulse each, app_data_request never asserted.
REQ-037 TIMEOUT_CYC=16, req0 len0=8, no ack -> app_data_request high 16 cycles, err0 pulse, return IDLE.
REQ-038 arp_busy high with req0 high -> no grant until arp_busy falls; src_valid0 toggling every other cycle during XFER -> app_data_in_valid mirrors it one cycle late, all 8 bytes in order.
REQ-039 rst pulsed during XFER after 2 of 8 bytes -> all outputs 0 next cycle, no done0/err0, next grant to requester 0.
